// File: rtl/elevator_pkg.sv
// Shared types and 7-segment constants for the elevator controller.
// Digit patterns are active-low, segment order {g,f,e,d,c,b,a}.
package elevator_pkg;

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [6:0] SEG7_0 = 7'h40;
    localparam logic [6:0] SEG7_1 = 7'h79;
    localparam logic [6:0] SEG7_2 = 7'h24;
    localparam logic [6:0] SEG7_3 = 7'h30;
    localparam logic [6:0] SEG7_4 = 7'h19;
    localparam logic [6:0] SEG7_5 = 7'h12;
    localparam logic [6:0] SEG7_6 = 7'h02;
    localparam logic [6:0] SEG7_7 = 7'h78;
    localparam logic [6:0] SEG7_8 = 7'h00;
    localparam logic [6:0] SEG7_9 = 7'h10;
    localparam logic [6:0] SEG7_F = 7'h0E;

    // Anything above 9 is shown as 'F'.
    function automatic logic [6:0] seg7_lookup(input logic [3:0] value);
        case (value)
            4'd0:    return SEG7_0;
            4'd1:    return SEG7_1;
            4'd2:    return SEG7_2;
            4'd3:    return SEG7_3;
            4'd4:    return SEG7_4;
            4'd5:    return SEG7_5;
            4'd6:    return SEG7_6;
            4'd7:    return SEG7_7;
            4'd8:    return SEG7_8;
            4'd9:    return SEG7_9;
            default: return SEG7_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Active-low 7-segment decoder for a 4-bit value (digits 0..9, 'F' above).
module seg7_decoder
    import elevator_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg_n
);

    // Pure table lookup, no state.
    always_comb begin
        seg_n = seg7_lookup(value);
    end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN (collective) elevator controller with door dwell timer.
// Optional feature: define ELEV_SEG7_EN to add the hex_n port showing
// cur_floor+1 on an active-low 7-segment display.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 4,
    parameter int DOOR_CYCLES = 50_000_000,
    localparam int FLOOR_W    = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  floor_tick,
    input  logic                  door_block,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  up,
    output logic                  down,
    output logic                  door_open,
    output logic                  complete,
    output logic                  tick_err
`ifdef ELEV_SEG7_EN
    ,
    output logic [6:0]            hex_n
`endif
);

    localparam int TIMER_W = $clog2(DOOR_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);

    state_t                  state, nxt_state;
    dir_t                    dir_last, nxt_dir;
    logic [TIMER_W-1:0]      timer, nxt_timer;
    logic [FLOOR_W-1:0]      nxt_floor;
    logic [NUM_FLOORS-1:0]   req, nxt_pending;
    logic                    nxt_err, nxt_complete, above, below;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i > int'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i < int'(f)) r = r | p[i];
        return r;
    endfunction

    // Keep going the way we last travelled while there is work that way.
    function automatic state_t pick_move(input logic a, input logic b, input dir_t d);
        if (d == DIR_UP) return a ? MOVE_UP : (b ? MOVE_DOWN : IDLE);
        return b ? MOVE_DOWN : (a ? MOVE_UP : IDLE);
    endfunction

    // Next-state, floor, timer and request bookkeeping.
    always_comb begin
        nxt_state = state;
        nxt_floor = cur_floor;
        nxt_timer = timer;
        nxt_dir   = dir_last;
        nxt_err   = tick_err;
        req       = pending | call_req;
        above     = any_above(pending, cur_floor);
        below     = any_below(pending, cur_floor);
        case (state)
            IDLE: begin
                if (floor_tick) nxt_err = 1'b1;
                if (req[cur_floor]) begin
                    nxt_state = DOOR_OPEN;
                    nxt_timer = TIMER_RELOAD;
                end else begin
                    nxt_state = pick_move(above, below, dir_last);
                end
            end
            MOVE_UP: begin
                nxt_dir = DIR_UP;
                if (floor_tick) begin
                    if (cur_floor == TOP_FLOOR) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_floor = cur_floor + 1'b1;
                        if (req[nxt_floor]) begin
                            nxt_state = DOOR_OPEN;
                            nxt_timer = TIMER_RELOAD;
                        end
                    end
                end
            end
            MOVE_DOWN: begin
                nxt_dir = DIR_DOWN;
                if (floor_tick) begin
                    if (cur_floor == '0) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_floor = cur_floor - 1'b1;
                        if (req[nxt_floor]) begin
                            nxt_state = DOOR_OPEN;
                            nxt_timer = TIMER_RELOAD;
                        end
                    end
                end
            end
            default: begin
                // A new call at this floor holds the door like an obstruction.
                if (floor_tick) nxt_err = 1'b1;
                if (door_block || call_req[cur_floor])
                    nxt_timer = TIMER_RELOAD;
                else if (timer != '0)
                    nxt_timer = timer - 1'b1;
                else
                    nxt_state = pick_move(above, below, dir_last);
            end
        endcase
        nxt_pending  = req;
        if (nxt_state == DOOR_OPEN)
            nxt_pending = req & ~(NUM_FLOORS'(1) << nxt_floor);
        nxt_complete = (nxt_state == DOOR_OPEN) && (state != DOOR_OPEN);
    end

    // State register with registered indications trailing the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dir_last  <= DIR_UP;
            timer     <= '0;
            cur_floor <= '0;
            pending   <= '0;
            up        <= 1'b0;
            down      <= 1'b0;
            door_open <= 1'b0;
            complete  <= 1'b0;
            tick_err  <= 1'b0;
        end else begin
            state     <= nxt_state;
            dir_last  <= nxt_dir;
            timer     <= nxt_timer;
            cur_floor <= nxt_floor;
            pending   <= nxt_pending;
            up        <= (state == MOVE_UP);
            down      <= (state == MOVE_DOWN);
            door_open <= (state == DOOR_OPEN);
            complete  <= nxt_complete;
            tick_err  <= nxt_err;
        end
    end

`ifdef ELEV_SEG7_EN
    logic [3:0] disp_value;

    // Floors are shown 1-based; values past 15 saturate (decoder shows 'F').
    always_comb begin
        disp_value = (int'(cur_floor) + 1 > 15) ? 4'd15 : 4'(int'(cur_floor) + 1);
    end

    seg7_decoder u_seg7 (
        .value (disp_value),
        .seg_n (hex_n)
    );
`endif

endmodule
